rotate_stage: RTL

ROTATE_STAGE -- requirements
Module: rotate_stage

---
 rtl/rotate_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/rotate_stage.sv
// rotate_stage: streams the 25 lanes of a 5x5 state through a fixed
// per-lane left rotation. Lanes are read from a source memory in address
// order (5*y+x), rotated by a hard-wired amount and written to a destination
// memory one cycle later. The source memory has one cycle of read latency.
module rotate_stage #(
  parameter int LANE_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [LANE_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LANE_W-1:0] wr_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(24);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] lane_cnt;
  int                rot_amt;
  logic [LANE_W-1:0] rotated;

  // Rotation offsets, indexed by lane address 5*y+x.
  function automatic int rot_offset(input logic [ADDR_W-1:0] addr);
    int r;
    case (int'(addr))
      0:  r = 0;   1:  r = 1;   2:  r = 62;  3:  r = 28;  4:  r = 27;
      5:  r = 36;  6:  r = 44;  7:  r = 6;   8:  r = 55;  9:  r = 20;
      10: r = 3;   11: r = 10;  12: r = 43;  13: r = 25;  14: r = 39;
      15: r = 41;  16: r = 45;  17: r = 15;  18: r = 21;  19: r = 8;
      20: r = 18;  21: r = 2;   22: r = 61;  23: r = 56;  24: r = 14;
      default: r = 0;
    endcase
    return r;
  endfunction

  // State register; reset aborts any pass in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (lane_cnt == LAST_LANE) state_nxt = FLUSH;
      FLUSH:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane counter: cleared on acceptance, saturates at the last lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt <= '0;
    end else if (state == IDLE && start) begin
      lane_cnt <= '0;
    end else if (state == RUN && lane_cnt != LAST_LANE) begin
      lane_cnt <= lane_cnt + ADDR_W'(1);
    end
  end

  assign rd_addr = (state == RUN) ? lane_cnt : '0;
  assign finish  = (state == FIN);
  assign busy    = (state != IDLE);

  // Write stage lines up with the read data arriving one cycle after the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en   <= (state == RUN);
      wr_addr <= rd_addr;
    end
  end

  // Lossless left rotation of the incoming lane by its table offset.
  always_comb begin
    rot_amt = rot_offset(wr_addr) % LANE_W;
    rotated = (rd_data << rot_amt) | (rd_data >> (LANE_W - rot_amt));
    wr_data = wr_en ? rotated : '0;
  end

endmodule
